logic_gate_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the successor to the single-bit two-input gates in `basics/`. It applies one of eight selectable gate functions across WIDTH-bit operands. It carries each operation through a two-stage registered pipeline with valid/ready flow control on both sides, and adds result flags and a completed-transfer counter. It sits between a producer and a consumer that both use the valid/ready handshake.

---
 rtl/logic_gate_pipe_if.sv | 28 ++
 rtl/logic_gate_pipe.sv | 82 ++++++++
 tb/tb_logic_gate_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pipe_if.sv
// Producer/consumer handshake bundle for logic_gate_pipe.
// master = the side driving operations and consuming results; slave = the unit.
interface logic_gate_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Y;
  logic               zero;
  logic               parity;
  logic [COUNT_W-1:0] xfer_count;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Y, zero, parity, xfer_count
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Y, zero, parity, xfer_count
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with zero/parity flags
// and a completed-output-handshake counter.
module logic_gate_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  logic_gate_pipe_if.slave   bus
);

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [2:0]         r_s1_op;

  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_y;
  logic               r_zero;
  logic               r_parity;
  logic [COUNT_W-1:0] r_xfer_count;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [WIDTH-1:0]   w_result;

  // An empty stage always advances, so bubbles collapse under backpressure.
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  always_comb begin
    w_result = '0;
    unique case (r_s1_op)
      3'd0: w_result = r_s1_a & r_s1_b;
      3'd1: w_result = r_s1_a | r_s1_b;
      3'd2: w_result = ~(r_s1_a & r_s1_b);
      3'd3: w_result = ~(r_s1_a | r_s1_b);
      3'd4: w_result = r_s1_a ^ r_s1_b;
      3'd5: w_result = ~(r_s1_a ^ r_s1_b);
      3'd6: w_result = ~r_s1_a;
      3'd7: w_result = r_s1_a;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_y          <= '0;
      r_zero       <= 1'b1;
      r_parity     <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_a  <= bus.A;
          r_s1_b  <= bus.B;
          r_s1_op <= bus.op;
        end
      end
      // Flags come from the same value as Y so they can never disagree.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_y        <= w_result;
        r_zero     <= (w_result == '0);
        r_parity   <= ^w_result;
      end
      if (r_s2_valid && bus.out_ready)
        r_xfer_count <= r_xfer_count + COUNT_W'(1);
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_valid;
  assign bus.Y          = r_y;
  assign bus.zero       = r_zero;
  assign bus.parity     = r_parity;
  assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: truth-table reference model, queue of
// expected results, negedge monitor; plus a COUNT_W=4 instance for counter wrap.
module tb_logic_gate_pipe;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .COUNT_W(16)) f ();
  logic_gate_pipe_if #(.WIDTH(8), .COUNT_W(4))  g ();

  logic_gate_pipe #(.WIDTH(8), .COUNT_W(16)) dut (.clk(clk), .rst(rst), .bus(f));
  logic_gate_pipe #(.WIDTH(8), .COUNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(g));

  int   total = 0;
  int   bad   = 0;
  int   hs_cnt = 0;
  exp_t exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y = '0;

  // Per-opcode truth table indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];
  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
  end

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ones;
    logic [3:0] t;
    t = tt[o];
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      e.y[i] = t[{a[i], b[i]}];
      if (e.y[i]) ones++;
    end
    e.z = (ones == 0);
    e.p = (ones % 2 == 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    f.in_valid = 1'b1;
    f.op = o;
    f.A = a;
    f.B = b;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    f.in_valid = 1'b0;
    f.out_ready = 1'b1;
    n = 0;
    while ((f.out_valid || exp_q.size() != 0) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) timeout(name);
  endtask

  // Monitor: occupancy-based in_ready check, stall stability, scoreboard pop/push.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hs_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      if (prev_stall) begin
        chk("stall_hold_y", 32'(f.Y), 32'(prev_y));
        chk("stall_hold_valid", 32'(f.out_valid), 32'd1);
      end
      chk("in_ready_occ", 32'(f.in_ready), 32'(!(exp_q.size() == 2 && !f.out_ready)));
      if (f.out_valid && f.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected actual=%0h required=none at %0t", f.Y, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_y", 32'(f.Y), 32'(e.y));
          chk("sb_zero", 32'(f.zero), 32'(e.z));
          chk("sb_parity", 32'(f.parity), 32'(e.p));
        end
      end
      if (f.in_valid && f.in_ready)
        exp_q.push_back(model(f.op, f.A, f.B));
      prev_stall = f.out_valid && !f.out_ready;
      prev_y = f.Y;
    end
  end

  logic [7:0] sweep [8];
  logic [2:0] bop [4];
  logic [7:0] ba [4];
  logic [7:0] bb [4];
  exp_t       first_e;

  initial begin
    sweep[0] = 8'hC0; sweep[1] = 8'hFC; sweep[2] = 8'h3F; sweep[3] = 8'h03;
    sweep[4] = 8'h3C; sweep[5] = 8'hC3; sweep[6] = 8'h0F; sweep[7] = 8'hF0;
    g.in_valid = 1'b0; g.out_ready = 1'b1; g.A = '0; g.B = '0; g.op = '0;

    // Reset with an operation offered throughout.
    f.out_ready = 1'b1;
    drive(3'd1, 8'hA5, 8'h5A);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    f.in_valid = 1'b0;
    chk("rst_out_valid", 32'(f.out_valid), 32'd0);
    chk("rst_in_ready", 32'(f.in_ready), 32'd1);
    chk("rst_y", 32'(f.Y), 32'd0);
    chk("rst_zero", 32'(f.zero), 32'd1);
    chk("rst_parity", 32'(f.parity), 32'd0);
    chk("rst_xfer", 32'(f.xfer_count), 32'd0);
    repeat (3) tick();
    chk("rst_no_output", 32'(f.out_valid), 32'd0);

    // Function sweep, one op per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), 8'hF0, 8'hCC);
      tick();
      if (k == 0) begin
        chk("lat_not_yet", 32'(f.out_valid), 32'd0);
      end else begin
        chk("sweep_valid", 32'(f.out_valid), 32'd1);
        chk("sweep_y", 32'(f.Y), 32'(sweep[k-1]));
        chk("sweep_parity", 32'(f.parity), 32'd0);
      end
    end
    f.in_valid = 1'b0;
    tick();
    chk("sweep_y_last", 32'(f.Y), 32'(sweep[7]));
    drain("sweep_drain");

    // Flags.
    drive(3'd0, 8'h0F, 8'hF0);
    tick();
    drive(3'd4, 8'h01, 8'h00);
    tick();
    chk("flag0_y", 32'(f.Y), 32'h00);
    chk("flag0_zero", 32'(f.zero), 32'd1);
    chk("flag0_parity", 32'(f.parity), 32'd0);
    f.in_valid = 1'b0;
    tick();
    chk("flag1_y", 32'(f.Y), 32'h01);
    chk("flag1_zero", 32'(f.zero), 32'd0);
    chk("flag1_parity", 32'(f.parity), 32'd1);
    drain("flag_drain");

    // Backpressure: 4 ops, 5-cycle stall after first result.
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      bop[i] = 3'($urandom_range(7));
      ba[i]  = 8'($urandom);
      bb[i]  = 8'($urandom);
    end
    first_e = model(bop[0], ba[0], bb[0]);
    f.out_ready = 1'b1;
    drive(bop[0], ba[0], bb[0]);
    tick();
    drive(bop[1], ba[1], bb[1]);
    tick();
    chk("bp_first_valid", 32'(f.out_valid), 32'd1);
    f.out_ready = 1'b0;
    drive(bop[2], ba[2], bb[2]);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_in_ready_low", 32'(f.in_ready), 32'd0);
      chk("bp_y_first", 32'(f.Y), 32'(first_e.y));
      tick();
      chk("bp_valid_held", 32'(f.out_valid), 32'd1);
    end
    f.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(f.in_ready), 32'd1);
    tick();
    drive(bop[3], ba[3], bb[3]);
    tick();
    drain("bp_drain");
    chk("bp_xfer", 32'(f.xfer_count), 32'd4);
    chk("bp_hs", 32'(hs_cnt), 32'd4);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      f.in_valid  = ($urandom_range(3) != 0);
      f.out_ready = ($urandom_range(2) != 0);
      tick();
    end
    drain("rand_drain");
    chk("rand_xfer", 32'(f.xfer_count), 32'(hs_cnt));

    // Reset with both stages full and stalled.
    f.out_ready = 1'b0;
    drive(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
    tick();
    drive(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
    tick();
    #1;
    chk("mid_full_in_ready", 32'(f.in_ready), 32'd0);
    chk("mid_full_valid", 32'(f.out_valid), 32'd1);
    f.in_valid = 1'b0;
    rst_pulse();
    chk("mid_rst_valid", 32'(f.out_valid), 32'd0);
    chk("mid_rst_xfer", 32'(f.xfer_count), 32'd0);
    chk("mid_rst_in_ready", 32'(f.in_ready), 32'd1);
    f.out_ready = 1'b1;
    repeat (4) tick();
    chk("mid_no_stale", 32'(f.out_valid), 32'd0);

    // Counter wrap on the COUNT_W=4 instance: 17 handshakes.
    rst_pulse();
    g.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      g.A = 8'($urandom);
      g.op = 3'($urandom_range(7));
      tick();
    end
    g.in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_xfer", 32'(g.xfer_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
